// File: rtl/trilinear_interp_axis.sv
// Streaming trilinear / nearest-neighbour interpolator over 8 lattice corners.
// Seven register stages (input, then multiply/add per axis R, G, B) under one global stall enable.
module trilinear_interp_axis #(
    parameter int FW     = 8,
    parameter int IN_CD  = 8,
    parameter int OUT_CD = IN_CD,
    parameter int NCH    = 3,
    parameter int GUARD  = 2,
    parameter int ROUND  = 1,
    parameter int USER_W = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FW-1:0]           frac_r,
    input  logic [FW-1:0]           frac_g,
    input  logic [FW-1:0]           frac_b,
    input  logic                    mode,
    input  logic [USER_W-1:0]       in_user,
    input  logic [NCH*IN_CD-1:0]    pt_nbr [8],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NCH*OUT_CD-1:0]   out_pt,
    output logic [USER_W-1:0]       out_user
);
    localparam int I_CD = IN_CD + GUARD;
    localparam int PW   = I_CD + FW + 1;
    localparam int D    = I_CD - OUT_CD;
    localparam int DS   = (D > 0) ? D - 1 : 0;
    localparam logic [FW:0]   W_ONE = {1'b1, {FW{1'b0}}};
    localparam logic [PW-1:0] HALF  = PW'(1) << (FW - 1);
    localparam logic [I_CD:0] RND   = (D > 0) ? ((I_CD + 1)'(1) << DS) : '0;
    localparam logic [I_CD:0] OMAX  = {{(I_CD + 1 - OUT_CD){1'b0}}, {OUT_CD{1'b1}}};

    function automatic logic [FW:0] w1_of(input logic [FW-1:0] f, input logic m);
        if (m) return f[FW-1] ? W_ONE : '0;
        return {1'b0, f};
    endfunction

    function automatic logic [PW-1:0] mul(input logic [I_CD-1:0] a, input logic [FW:0] w);
        return PW'(a) * PW'(w);
    endfunction

    // Weights sum to 2^FW, so the rounded sum never exceeds the larger corner.
    function automatic logic [I_CD-1:0] lerp_sum(input logic [PW-1:0] pa, input logic [PW-1:0] pb);
        logic [PW-1:0] s;
        s = pa + pb + HALF;
        return s[FW +: I_CD];
    endfunction

    function automatic logic [OUT_CD-1:0] narrow(input logic [I_CD-1:0] v);
        logic [I_CD:0] t;
        t = {1'b0, v};
        if (ROUND != 0) t = t + RND;
        t = t >> D;
        if (t > OMAX) t = OMAX;
        return t[OUT_CD-1:0];
    endfunction

    logic                  ce;
    logic [FW:0]           w1_r, w1_g, w1_b;
    logic [5:0]            v_q, v_d;
    logic [USER_W-1:0]     user_q [6], user_d [6];
    logic [I_CD-1:0]       s0_pt_q [8][NCH], s0_pt_d [8][NCH];
    logic [FW:0]           s0_w_q [6], s0_w_d [6];
    logic [PW-1:0]         s1_pa_q [4][NCH], s1_pa_d [4][NCH];
    logic [PW-1:0]         s1_pb_q [4][NCH], s1_pb_d [4][NCH];
    logic [FW:0]           s1_w_q [4], s1_w_d [4];
    logic [I_CD-1:0]       s2_pt_q [4][NCH], s2_pt_d [4][NCH];
    logic [FW:0]           s2_w_q [4], s2_w_d [4];
    logic [PW-1:0]         s3_pa_q [2][NCH], s3_pa_d [2][NCH];
    logic [PW-1:0]         s3_pb_q [2][NCH], s3_pb_d [2][NCH];
    logic [FW:0]           s3_w_q [2], s3_w_d [2];
    logic [I_CD-1:0]       s4_pt_q [2][NCH], s4_pt_d [2][NCH];
    logic [FW:0]           s4_w_q [2], s4_w_d [2];
    logic [PW-1:0]         s5_pa_q [NCH], s5_pa_d [NCH];
    logic [PW-1:0]         s5_pb_q [NCH], s5_pb_d [NCH];
    logic                  out_valid_q, out_valid_d;
    logic [NCH*OUT_CD-1:0] out_pt_q, out_pt_d;
    logic [USER_W-1:0]     out_user_q, out_user_d;

    // Handshake: a beat moves on any edge where ce is high; in_ready mirrors ce
    // so the source sees a stall combinationally and holds its beat.
    assign ce        = !out_valid_q || out_ready;
    assign in_ready  = ce;
    assign out_valid = out_valid_q;
    assign out_pt    = out_pt_q;
    assign out_user  = out_user_q;

    always_comb begin
        w1_r        = w1_of(frac_r, mode);
        w1_g        = w1_of(frac_g, mode);
        w1_b        = w1_of(frac_b, mode);
        v_d         = v_q;
        user_d      = user_q;
        s0_pt_d     = s0_pt_q;
        s0_w_d      = s0_w_q;
        s1_pa_d     = s1_pa_q;
        s1_pb_d     = s1_pb_q;
        s1_w_d      = s1_w_q;
        s2_pt_d     = s2_pt_q;
        s2_w_d      = s2_w_q;
        s3_pa_d     = s3_pa_q;
        s3_pb_d     = s3_pb_q;
        s3_w_d      = s3_w_q;
        s4_pt_d     = s4_pt_q;
        s4_w_d      = s4_w_q;
        s5_pa_d     = s5_pa_q;
        s5_pb_d     = s5_pb_q;
        out_valid_d = out_valid_q;
        out_pt_d    = out_pt_q;
        out_user_d  = out_user_q;
        if (ce) begin
            v_d       = {v_q[4:0], in_valid};
            user_d[0] = in_user;
            for (int i = 1; i < 6; i++) user_d[i] = user_q[i-1];
            s0_w_d = '{W_ONE - w1_r, w1_r, W_ONE - w1_g, w1_g, W_ONE - w1_b, w1_b};
            s1_w_d = '{s0_w_q[2], s0_w_q[3], s0_w_q[4], s0_w_q[5]};
            s2_w_d = s1_w_q;
            s3_w_d = '{s2_w_q[2], s2_w_q[3]};
            s4_w_d = s3_w_q;
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < 8; k++)
                    s0_pt_d[k][c] = I_CD'(pt_nbr[k][c*IN_CD +: IN_CD]) << GUARD;
                // R axis pairs corners differing in bit 0 of the index.
                for (int j = 0; j < 4; j++) begin
                    s1_pa_d[j][c] = mul(s0_pt_q[2*j][c], s0_w_q[0]);
                    s1_pb_d[j][c] = mul(s0_pt_q[2*j+1][c], s0_w_q[1]);
                    s2_pt_d[j][c] = lerp_sum(s1_pa_q[j][c], s1_pb_q[j][c]);
                end
                for (int m = 0; m < 2; m++) begin
                    s3_pa_d[m][c] = mul(s2_pt_q[2*m][c], s2_w_q[0]);
                    s3_pb_d[m][c] = mul(s2_pt_q[2*m+1][c], s2_w_q[1]);
                    s4_pt_d[m][c] = lerp_sum(s3_pa_q[m][c], s3_pb_q[m][c]);
                end
                s5_pa_d[c] = mul(s4_pt_q[0][c], s4_w_q[0]);
                s5_pb_d[c] = mul(s4_pt_q[1][c], s4_w_q[1]);
                out_pt_d[c*OUT_CD +: OUT_CD] = narrow(lerp_sum(s5_pa_q[c], s5_pb_q[c]));
            end
            out_valid_d = v_q[5];
            out_user_d  = user_q[5];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q         <= '0;
            user_q      <= '{default: '0};
            s0_pt_q     <= '{default: '0};
            s0_w_q      <= '{default: '0};
            s1_pa_q     <= '{default: '0};
            s1_pb_q     <= '{default: '0};
            s1_w_q      <= '{default: '0};
            s2_pt_q     <= '{default: '0};
            s2_w_q      <= '{default: '0};
            s3_pa_q     <= '{default: '0};
            s3_pb_q     <= '{default: '0};
            s3_w_q      <= '{default: '0};
            s4_pt_q     <= '{default: '0};
            s4_w_q      <= '{default: '0};
            s5_pa_q     <= '{default: '0};
            s5_pb_q     <= '{default: '0};
            out_valid_q <= 1'b0;
            out_pt_q    <= '0;
            out_user_q  <= '0;
        end else begin
            v_q         <= v_d;
            user_q      <= user_d;
            s0_pt_q     <= s0_pt_d;
            s0_w_q      <= s0_w_d;
            s1_pa_q     <= s1_pa_d;
            s1_pb_q     <= s1_pb_d;
            s1_w_q      <= s1_w_d;
            s2_pt_q     <= s2_pt_d;
            s2_w_q      <= s2_w_d;
            s3_pa_q     <= s3_pa_d;
            s3_pb_q     <= s3_pb_d;
            s3_w_q      <= s3_w_d;
            s4_pt_q     <= s4_pt_d;
            s4_w_q      <= s4_w_d;
            s5_pa_q     <= s5_pa_d;
            s5_pb_q     <= s5_pb_d;
            out_valid_q <= out_valid_d;
            out_pt_q    <= out_pt_d;
            out_user_q  <= out_user_d;
        end
    end
endmodule

// File: tb/tb_trilinear_interp_axis.sv
// Bench for trilinear_interp_axis: rounding and truncating instances share one stimulus stream
// and are checked against an arithmetic reference model and an expected-value queue.
module tb_trilinear_interp_axis;
    localparam int FW = 8, IN_CD = 8, OUT_CD = 8, NCH = 3, GUARD = 2, USER_W = 8;
    localparam int PTW = NCH * IN_CD;
    localparam int OW  = NCH * OUT_CD;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0, out_ready = 1'b1, mode = 1'b0;
    logic [FW-1:0]     frac_r = '0, frac_g = '0, frac_b = '0;
    logic [USER_W-1:0] in_user = '0;
    logic [PTW-1:0]    pt [8];
    logic              in_ready, out_valid, in_ready_t, out_valid_t;
    logic [OW-1:0]     out_pt, out_pt_t;
    logic [USER_W-1:0] out_user, out_user_t;

    trilinear_interp_axis #(.FW(FW), .IN_CD(IN_CD), .OUT_CD(OUT_CD), .NCH(NCH), .GUARD(GUARD),
                            .ROUND(1), .USER_W(USER_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .frac_r(frac_r), .frac_g(frac_g), .frac_b(frac_b), .mode(mode), .in_user(in_user),
        .pt_nbr(pt), .out_valid(out_valid), .out_ready(out_ready), .out_pt(out_pt), .out_user(out_user));

    trilinear_interp_axis #(.FW(FW), .IN_CD(IN_CD), .OUT_CD(OUT_CD), .NCH(NCH), .GUARD(GUARD),
                            .ROUND(0), .USER_W(USER_W)) dut_t (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_t),
        .frac_r(frac_r), .frac_g(frac_g), .frac_b(frac_b), .mode(mode), .in_user(in_user),
        .pt_nbr(pt), .out_valid(out_valid_t), .out_ready(out_ready), .out_pt(out_pt_t), .out_user(out_user_t));

    int tests = 0, fails = 0, cyc = 0, retired = 0;
    logic [OW-1:0]     exp_q[$], exp_t_q[$];
    logic [USER_W-1:0] exp_u_q[$];
    int                acc_q[$];
    bit                chk_lat = 1'b1, prev_stall = 1'b0, acc = 1'b0, saw = 1'b0;
    logic [OW-1:0]     prev_pt, seen_pt, seen_pt_t;
    logic [USER_W-1:0] prev_user;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint lerp(input longint a, input longint b, input int f, input bit m);
        longint w1, w0;
        if (m) w1 = (f >= (1 << (FW - 1))) ? longint'(1 << FW) : 0;
        else   w1 = f;
        w0 = (1 << FW) - w1;
        return (a * w0 + b * w1 + (1 << (FW - 1))) >> FW;
    endfunction

    function automatic logic [OW-1:0] model(input bit rnd);
        logic [OW-1:0] r;
        longint v [8];
        longint x;
        int d;
        r = '0;
        d = IN_CD + GUARD - OUT_CD;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 8; k++) v[k] = longint'(pt[k][c*IN_CD +: IN_CD]) << GUARD;
            for (int j = 0; j < 4; j++) v[j] = lerp(v[2*j], v[2*j+1], int'(frac_r), mode);
            for (int m = 0; m < 2; m++) v[m] = lerp(v[2*m], v[2*m+1], int'(frac_g), mode);
            x = lerp(v[0], v[1], int'(frac_b), mode);
            if (rnd) begin
                if (d > 0) x = (x + (1 << (d - 1))) >> d;
                if (x > (1 << OUT_CD) - 1) x = (1 << OUT_CD) - 1;
            end else begin
                x = x >> d;
            end
            r[c*OUT_CD +: OUT_CD] = x[OUT_CD-1:0];
        end
        return r;
    endfunction

    // One clock: check outputs and record acceptance at the falling edge, then pass the rising edge.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        saw = 1'b0;
        if (out_valid) begin
            saw = 1'b1;
            seen_pt = out_pt;
            seen_pt_t = out_pt_t;
            chk("valid_pair", out_valid_t, 1);
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                chk("out_pt", out_pt, exp_q[0]);
                chk("out_pt_trunc", out_pt_t, exp_t_q[0]);
                chk("out_user", out_user, exp_u_q[0]);
                if (chk_lat) chk("latency", (cyc - 1) - acc_q[0], 6);
                else         chk("min_latency", ((cyc - 1) - acc_q[0]) >= 6, 1);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_t_q.pop_front());
                    void'(exp_u_q.pop_front());
                    void'(acc_q.pop_front());
                    retired++;
                end
            end
        end
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_pt", out_pt, prev_pt);
            chk("stall_user", out_user, prev_user);
        end
        prev_stall = out_valid && !out_ready;
        prev_pt = out_pt;
        prev_user = out_user;
        chk("in_ready", in_ready, !out_valid || out_ready);
        acc = in_valid && in_ready;
        if (acc) begin
            exp_q.push_back(model(1'b1));
            exp_t_q.push_back(model(1'b0));
            exp_u_q.push_back(in_user);
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        for (int k = 0; k < 8; k++) pt[k] = PTW'($urandom);
        frac_r = FW'($urandom_range(0, (1 << FW) - 1));
        frac_g = FW'($urandom_range(0, (1 << FW) - 1));
        frac_b = FW'($urandom_range(0, (1 << FW) - 1));
    endtask

    task automatic set_corners(input logic [IN_CD-1:0] ev, input logic [IN_CD-1:0] od);
        for (int k = 0; k < 8; k++) pt[k] = (k % 2 == 1) ? {NCH{od}} : {NCH{ev}};
    endtask

    task automatic send_wait(input string tag, input logic [OW-1:0] e1, input logic [OW-1:0] e0);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (saw) break;
        end
        chk({tag, "_seen"}, saw, 1);
        chk({tag, "_r1"}, seen_pt, e1);
        chk({tag, "_r0"}, seen_pt_t, e0);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) pt[k] = '0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_pt", out_pt, 0);
        chk("rst_user", out_user, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (3) cycle();
        rstn = 1'b1;
        repeat (2) cycle();

        // Saturation / no overflow: all corners full scale.
        for (int i = 0; i < 3; i++) begin
            rand_beat();
            set_corners('1, '1);
            in_user = USER_W'(i);
            send_wait("full_scale", {OW{1'b1}}, {OW{1'b1}});
        end

        rand_beat();
        set_corners(8'd0, 8'd100);
        frac_r = 8'd128;
        send_wait("half_100", {NCH{8'd50}}, {NCH{8'd50}});

        set_corners(8'd0, 8'd1);
        send_wait("half_1", {NCH{8'd1}}, {NCH{8'd0}});

        set_corners(8'd0, 8'd100);
        mode = 1'b1;
        frac_r = 8'd127;
        send_wait("near_127", {NCH{8'd0}}, {NCH{8'd0}});
        frac_r = 8'd128;
        send_wait("near_128", {NCH{8'd100}}, {NCH{8'd100}});
        mode = 1'b0;

        for (int i = 0; i < 4; i++) begin
            rand_beat();
            mode = 1'($urandom_range(0, 1));
            send_wait("random_dir", model(1'b1), model(1'b0));
        end

        // Back-pressured stream with incrementing sideband.
        chk_lat = 1'b0;
        retired = 0;
        begin
            int sent = 0;
            for (int n = 0; n < 2000 && sent < 20; n++) begin
                if (!in_valid) begin
                    rand_beat();
                    mode = 1'($urandom_range(0, 1));
                    in_user = USER_W'(sent);
                    in_valid = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'($urandom_range(0, 1));
                cycle();
                if (acc) begin
                    sent++;
                    in_valid = 1'b0;
                end
            end
            in_valid = 1'b0;
            chk("stream_sent", sent, 20);
        end
        out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) cycle();
        chk("stream_drained", exp_q.size(), 0);
        chk("stream_retired", retired, 20);
        repeat (3) cycle();

        // Asynchronous reset with beats in flight and the output stalled.
        chk_lat = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_beat();
            in_user = USER_W'(8'hA0 + i);
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (saw) break;
        end
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_valid_t", out_valid_t, 0);
        chk("async_rst_pt", out_pt, 0);
        chk("async_rst_user", out_user, 0);
        chk("async_rst_in_ready", in_ready, 1);
        exp_q.delete();
        exp_t_q.delete();
        exp_u_q.delete();
        acc_q.delete();
        prev_stall = 1'b0;
        repeat (2) cycle();
        rstn = 1'b1;
        out_ready = 1'b1;
        repeat (12) cycle();
        rand_beat();
        in_user = USER_W'(8'h5A);
        send_wait("post_rst", model(1'b1), model(1'b0));
        repeat (8) cycle();
        chk("final_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/trilinear_interp_axis.md
# trilinear_interp_axis

Parametrised, streaming successor of the fixed 3-channel trilinear interpolator. It generalises channel count, guard precision and output rounding, and adds a per-transaction nearest-neighbour mode and a sideband pass-through. It uses a full valid/ready handshake so it can sit between a 3D-LUT fetch stage and a back-pressuring video output. It is a fully pipelined datapath: one result per cycle when unstalled, fixed latency.

## Interface
- FW, 8: fractional weight width per axis
- IN_CD, 8: input bits per channel
- OUT_CD, IN_CD: output bits per channel; must satisfy 1 ≤ OUT_CD ≤ IN_CD
- NCH, 3: channels per lattice point; channel c occupies bits [c*IN_CD +: IN_CD]
- GUARD, 2: extra internal LSBs; internal width I_CD = IN_CD+GUARD
- ROUND, 1: 1 = round-half-up with saturation on final narrowing; 0 = truncate
- USER_W, 1: sideband width
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- frac_r, frac_g, frac_b  in  FW each  axis fractions; weight = frac/2^FW
- mode  in  1  0 = trilinear, 1 = nearest
- in_user  in  USER_W  sideband, carried alongside the data
- pt_nbr[7:0]  in  NCH*IN_CD each  lattice corners; index = 4*b + 2*g + r (bit0 = R axis)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_pt  out  NCH*OUT_CD  interpolated point, same channel packing
- out_user  out  USER_W  sideband of this beat

## Operation
- Corners are left-aligned into I_CD bits: `{x, GUARD'b0}`.
- Weights are FW+1 bits wide:
  - trilinear: w1 = frac, w0 = 2^FW − frac
  - nearest: w1 = 2^FW if frac ≥ 2^(FW−1), else 0; w0 = 2^FW − w1
  - Nearest mode uses the same datapath and has the same latency.
- Axis order is R (8→4 points), then G (4→2), then B (2→1). Each axis uses a multiply stage followed by an add stage.
- Lerp per channel: L(a,b) = (a*w0 + b*w1 + 2^(FW−1)) >> FW.
  - The sum is computed exactly in I_CD+FW+1 bits.
  - The result fits in I_CD bits with no overflow: equal corners produce themselves exactly.
- Final narrowing from I_CD to OUT_CD, with D = I_CD − OUT_CD:
  - ROUND=1: out = min((v + 2^(D−1)) >> D, 2^OUT_CD − 1)
  - ROUND=0: out = v >> D
- Per-beat controls (frac_g, frac_b, mode, user) are delayed alongside the data so every stage uses its own beat's values. No cross-beat mixing is permitted.
- Stall model: global enable ce = !out_valid || out_ready.
  - All pipeline registers, including per-stage valid bits, advance only when ce = 1.
  - in_ready = ce, combinational. It is high whenever the output register is empty or being drained.
- The input is accepted when in_valid && in_ready. Data presented while in_ready = 0 is ignored and must be held by the source.
- Bubbles (invalid stages) propagate and are squeezed out only through the output stage. There is no internal compaction.

## Timing
- Latency is 6 ce-cycles. A beat accepted at edge N appears with out_valid=1 after edge N+6 when no stall occurs.
- Throughput is 1 beat/cycle while out_ready = 1.
- While out_valid && !out_ready:
  - out_pt and out_user are held stable.
  - All stages freeze and in_ready = 0.
- Simultaneous out_ready=1 with a new input: output retires and input enters in the same cycle.
- Reset (rstn low, asynchronous) clears all valid bits, out_valid, out_pt and out_user to 0 immediately.
- Reset mid-stream discards all in-flight beats. in_ready = 1 during and after reset, because out_valid = 0.
- No output may appear earlier than 6 cycles after the first post-reset acceptance.

## Test plan
- All corners 255 in every channel, random fracs, NCH=3, ROUND=1 → out_pt 255 in every channel; checks saturation and no overflow.
- Even-index corners 0, odd-index corners 100, frac_r=128, other fracs random → every channel 50, output 6 cycles after acceptance.
- Even-index corners 0, odd-index corners 1, frac_r=128 → ROUND=1 gives 1, ROUND=0 gives 0.
- mode=1 with the corner set from scenario 2: frac_r=127 → 0; frac_r=128 → 100. Latency is identical to trilinear mode.
- Stream of 20 beats with incrementing in_user, random out_ready (about 50%) → all 20 outputs are in order and match the reference model; out_pt and out_user stay stable while stalled; none are lost or duplicated.
- Assert rstn low with 4 beats in flight → out_valid drops to 0 asynchronously; after release, no stale beat ever emerges, and a new beat emerges exactly 6 cycles after acceptance.
